// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer
// Sits in front of a busy-flag HD44780-style LCD driver. After reset it
// waits out the LCD power-on delay and plays a fixed five-command init
// sequence. It then forwards single command/data bytes from one user port
// through the driver's en/done handshake. A watchdog bounds every transfer:
// a missing done pulse sets a sticky error and the transfer is treated as
// finished so the sequencer never stalls.
module lcd_cmd_sequencer #(
    parameter int                   SIZE_DATA       = 8,
    parameter int                   SIZE_FUNC       = 4,
    parameter int                   PWR_ON_WAIT_CYC = 750000,
    parameter int                   TIMEOUT_CYC     = 2000000,
    parameter logic [SIZE_FUNC-1:0] FUNC_CMD        = 'h0,
    parameter logic [SIZE_FUNC-1:0] FUNC_DATA       = 'h1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_req_rs,
    input  logic [SIZE_DATA-1:0] i_req_data,
    output logic                 o_req_ack,
    output logic                 o_ready,
    output logic                 o_init_done,
    output logic                 o_err,
    output logic                 o_en_lcd,
    output logic [SIZE_DATA-1:0] o_data,
    output logic [SIZE_FUNC-1:0] o_func,
    input  logic                 i_done_lcd
);

    localparam int PW_W = $clog2(PWR_ON_WAIT_CYC + 1);
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    localparam logic [PW_W-1:0] PW_LAST   = PW_W'(PWR_ON_WAIT_CYC - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [2:0]      INIT_LAST = 3'd4;

    typedef enum logic [2:0] {
        S_PWR_WAIT,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_IDLE,
        S_USER_WAIT
    } state_t;

    state_t                 state_q, state_d;
    logic [PW_W-1:0]        pwr_cnt_q, pwr_cnt_d;
    logic [TO_W-1:0]        wd_cnt_q, wd_cnt_d;
    logic [2:0]             idx_q, idx_d;
    logic                   en_q, en_d;
    logic                   ack_q, ack_d;
    logic                   ready_q, ready_d;
    logic                   init_done_q, init_done_d;
    logic                   err_q, err_d;
    logic [SIZE_DATA-1:0]   data_q, data_d;
    logic [SIZE_FUNC-1:0]   func_q, func_d;

    logic                   wd_expired;
    logic                   xfer_end;

    // Init command ROM: function set, display on, clear, entry mode, home address.
    function automatic logic [SIZE_DATA-1:0] init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    init_rom = SIZE_DATA'(8'h38);
            3'd1:    init_rom = SIZE_DATA'(8'h0C);
            3'd2:    init_rom = SIZE_DATA'(8'h01);
            3'd3:    init_rom = SIZE_DATA'(8'h06);
            default: init_rom = SIZE_DATA'(8'h80);
        endcase
    endfunction

    // A real done wins over a coincident timeout, so the error flag only
    // reflects transfers that truly never completed.
    assign wd_expired = (wd_cnt_q == TO_LAST);
    assign xfer_end   = i_done_lcd || wd_expired;

    // Next-state and registered-output logic for the sequencer FSM.
    always_comb begin
        state_d     = state_q;
        pwr_cnt_d   = pwr_cnt_q;
        wd_cnt_d    = wd_cnt_q;
        idx_d       = idx_q;
        en_d        = 1'b0;
        ack_d       = 1'b0;
        ready_d     = ready_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        data_d      = data_q;
        func_d      = func_q;

        case (state_q)
            S_PWR_WAIT: begin
                if (pwr_cnt_q == PW_LAST) begin
                    state_d = S_INIT_ISSUE;
                end else begin
                    pwr_cnt_d = pwr_cnt_q + PW_W'(1);
                end
            end

            S_INIT_ISSUE: begin
                data_d   = init_rom(idx_q);
                func_d   = FUNC_CMD;
                en_d     = 1'b1;
                wd_cnt_d = '0;
                state_d  = S_INIT_WAIT;
            end

            S_INIT_WAIT: begin
                if (xfer_end) begin
                    if (!i_done_lcd) begin
                        err_d = 1'b1;
                    end
                    if (idx_q == INIT_LAST) begin
                        init_done_d = 1'b1;
                        ready_d     = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = S_INIT_ISSUE;
                    end
                end else begin
                    wd_cnt_d = wd_cnt_q + TO_W'(1);
                end
            end

            S_IDLE: begin
                if (i_req) begin
                    data_d   = i_req_data;
                    func_d   = i_req_rs ? FUNC_DATA : FUNC_CMD;
                    en_d     = 1'b1;
                    ack_d    = 1'b1;
                    ready_d  = 1'b0;
                    wd_cnt_d = '0;
                    state_d  = S_USER_WAIT;
                end
            end

            S_USER_WAIT: begin
                if (xfer_end) begin
                    if (!i_done_lcd) begin
                        err_d = 1'b1;
                    end
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + TO_W'(1);
                end
            end

            default: begin
                state_d = S_PWR_WAIT;
            end
        endcase
    end

    // State and output registers; reset restarts the whole power-on sequence.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_PWR_WAIT;
            pwr_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            idx_q       <= '0;
            en_q        <= 1'b0;
            ack_q       <= 1'b0;
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            func_q      <= FUNC_CMD;
        end else begin
            state_q     <= state_d;
            pwr_cnt_q   <= pwr_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            ack_q       <= ack_d;
            ready_q     <= ready_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
            data_q      <= data_d;
            func_q      <= func_d;
        end
    end

    assign o_req_ack   = ack_q;
    assign o_ready     = ready_q;
    assign o_init_done = init_done_q;
    assign o_err       = err_q;
    assign o_en_lcd    = en_q;
    assign o_data      = data_q;
    assign o_func      = func_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// Testbench for lcd_cmd_sequencer: a cycle-stepped driver model answers
// each en pulse after a programmable latency (or never, for a chosen byte),
// and every transfer is compared against an expected list built from the
// init ROM and the user requests, with timing predicted arithmetically.
module tb_lcd_cmd_sequencer;

    localparam int PWR = 20;
    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_req;
    logic       i_req_rs;
    logic [7:0] i_req_data;
    logic       i_done_lcd;
    logic       o_req_ack;
    logic       o_ready;
    logic       o_init_done;
    logic       o_err;
    logic       o_en_lcd;
    logic [7:0] o_data;
    logic [3:0] o_func;

    always #5 clk = ~clk;

    lcd_cmd_sequencer #(
        .SIZE_DATA      (8),
        .SIZE_FUNC      (4),
        .PWR_ON_WAIT_CYC(PWR),
        .TIMEOUT_CYC    (TMO),
        .FUNC_CMD       (4'h0),
        .FUNC_DATA      (4'h1)
    ) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_req      (i_req),
        .i_req_rs   (i_req_rs),
        .i_req_data (i_req_data),
        .o_req_ack  (o_req_ack),
        .o_ready    (o_ready),
        .o_init_done(o_init_done),
        .o_err      (o_err),
        .o_en_lcd   (o_en_lcd),
        .o_data     (o_data),
        .o_func     (o_func),
        .i_done_lcd (i_done_lcd)
    );

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rel = 0;
    int          drv_lat = 5;
    int          drv_cnt = 0;
    logic        mute_en = 1'b0;
    logic [7:0]  mute_byte = 8'h00;
    logic        force_done = 1'b0;
    logic [11:0] en_log[$];
    int          en_cyc[$];
    int          ack_cyc[$];
    int          ack_bad = 0;
    logic        prev_ready = 1'b0;
    logic        prev_err = 1'b0;
    int          err_cyc = -1;
    logic [7:0]  rom[5] = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h80};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs after the edge, run the driver model, log events.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        i_done_lcd = 1'b0;
        if (o_en_lcd) begin
            en_log.push_back({o_func, o_data});
            en_cyc.push_back(cyc - rel);
            if (!(mute_en && o_data == mute_byte)) drv_cnt = drv_lat;
        end
        if (drv_cnt > 0) begin
            drv_cnt--;
            if (drv_cnt == 0) i_done_lcd = 1'b1;
        end
        if (force_done) i_done_lcd = 1'b1;
        if (o_req_ack) begin
            ack_cyc.push_back(cyc);
            if (!prev_ready) ack_bad++;
        end
        if (o_err && !prev_err) err_cyc = cyc - rel;
        prev_ready = o_ready;
        prev_err   = o_err;
    endtask

    task automatic do_reset(input int n);
        i_rst   = 1'b1;
        i_req   = 1'b0;
        drv_cnt = 0;
        repeat (n) step();
        i_rst = 1'b0;
        rel   = cyc;
        err_cyc = -1;
        en_log.delete();
        en_cyc.delete();
    endtask

    task automatic wait_init(input int budget);
        int g = 0;
        while (!o_init_done && g < budget) begin
            step();
            g++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},        32'(o_en_lcd),    0);
        chk({tag, "_ack"},       32'(o_req_ack),   0);
        chk({tag, "_ready"},     32'(o_ready),     0);
        chk({tag, "_init_done"}, 32'(o_init_done), 0);
        chk({tag, "_err"},       32'(o_err),       0);
        chk({tag, "_data"},      32'(o_data),      0);
        chk({tag, "_func"},      32'(o_func),      0);
    endtask

    // Normal init with fixed latency: en k at PWR+1 + k*(lat+1), done lat later.
    task automatic check_normal_init(input string tag, input int lat);
        int t_done;
        wait_init(400);
        t_done = cyc - rel;
        chk({tag, "_init_done"}, 32'(o_init_done), 1);
        chk({tag, "_ready"},     32'(o_ready),     1);
        chk({tag, "_n_en"},      en_log.size(),    5);
        for (int k = 0; k < 5; k++) begin
            if (k < en_log.size()) begin
                chk($sformatf("%s_byte%0d", tag, k), 32'(en_log[k]), 32'({4'h0, rom[k]}));
                chk($sformatf("%s_encyc%0d", tag, k), en_cyc[k], PWR + 1 + k * (lat + 1));
            end
        end
        chk({tag, "_done_cyc"}, t_done, PWR + 1 + 4 * (lat + 1) + lat);
    endtask

    // Hold i_req high across n requests with random bytes and driver latencies.
    task automatic burst(input string tag, input int n, input logic first_fixed);
        logic [8:0]  reqs[$];
        int          lats[$];
        logic [11:0] exp_q[$];
        int          idx = 0;
        int          g = 0;
        reqs.delete();
        lats.delete();
        exp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (first_fixed && k == 0)      reqs.push_back({1'b1, 8'h48});
            else if (first_fixed && k == 1) reqs.push_back({1'b1, 8'h49});
            else reqs.push_back({1'($urandom_range(1, 0)), 8'($urandom_range(255, 0))});
            lats.push_back(int'($urandom_range(6, 1)));
            exp_q.push_back({3'b000, reqs[k][8], reqs[k][7:0]});
        end
        en_log.delete();
        ack_cyc.delete();
        ack_bad = 0;
        drv_lat = lats[0];
        i_req_rs   = reqs[0][8];
        i_req_data = reqs[0][7:0];
        i_req      = 1'b1;
        while (idx < n && g < 500) begin
            step();
            g++;
            if (o_req_ack) begin
                idx++;
                if (idx < n) begin
                    drv_lat    = lats[idx];
                    i_req_rs   = reqs[idx][8];
                    i_req_data = reqs[idx][7:0];
                end else begin
                    i_req = 1'b0;
                end
            end
        end
        i_req = 1'b0;
        g = 0;
        while (!o_ready && g < 50) begin
            step();
            g++;
        end
        chk({tag, "_n_ack"},   ack_cyc.size(), n);
        chk({tag, "_n_en"},    en_log.size(),  n);
        chk({tag, "_ack_bad"}, ack_bad,        0);
        for (int k = 0; k < n; k++) begin
            if (k < en_log.size())
                chk($sformatf("%s_xfer%0d", tag, k), 32'(en_log[k]), 32'(exp_q[k]));
            if (k + 1 < ack_cyc.size())
                chk($sformatf("%s_gap%0d", tag, k), ack_cyc[k + 1] - ack_cyc[k], lats[k] + 1);
        end
        chk({tag, "_ready_end"}, 32'(o_ready), 1);
    endtask

    initial begin
        int a_cyc;
        int g;
        i_rst      = 1'b1;
        i_req      = 1'b0;
        i_req_rs   = 1'b0;
        i_req_data = 8'h00;
        i_done_lcd = 1'b0;

        // ---------------- Run A: normal init ----------------
        drv_lat = 5;
        do_reset(2);
        check_reset_outputs("rst_a");
        check_normal_init("init_a", 5);

        // Single data write 'A'
        drv_lat = 5;
        en_log.delete();
        i_req_rs   = 1'b1;
        i_req_data = 8'h41;
        i_req      = 1'b1;
        step();
        i_req = 1'b0;
        a_cyc = cyc;
        chk("a_ack",   32'(o_req_ack), 1);
        chk("a_en",    32'(o_en_lcd),  1);
        chk("a_data",  32'(o_data),    32'h41);
        chk("a_func",  32'(o_func),    1);
        chk("a_ready", 32'(o_ready),   0);
        g = 0;
        while (!o_ready && g < 100) begin
            step();
            g++;
        end
        chk("a_ready_delay", cyc - a_cyc, 5);
        chk("a_data_hold",   32'(o_data), 32'h41);
        chk("a_n_en",        en_log.size(), 1);

        // Held request with data stepping
        burst("hold", 6, 1'b1);

        // Done pulses while idle must not disturb anything
        en_log.delete();
        force_done = 1'b1;
        repeat (3) step();
        force_done = 1'b0;
        step();
        chk("idle_done_ready", 32'(o_ready), 1);
        chk("idle_done_en",    en_log.size(), 0);
        chk("idle_done_err",   32'(o_err), 0);

        // Done coincident with the timeout cycle counts as a normal done
        mute_en    = 1'b1;
        mute_byte  = 8'h5A;
        i_req_rs   = 1'b0;
        i_req_data = 8'h5A;
        i_req      = 1'b1;
        step();
        i_req = 1'b0;
        a_cyc = cyc;
        chk("tmo_eq_ack", 32'(o_req_ack), 1);
        repeat (TMO - 2) step();
        force_done = 1'b1;
        step();
        force_done = 1'b0;
        chk("tmo_eq_wait_ready", 32'(o_ready), 0);
        step();
        chk("tmo_eq_cyc",   cyc - a_cyc, TMO);
        chk("tmo_eq_err",   32'(o_err),  0);
        chk("tmo_eq_ready", 32'(o_ready), 1);

        // Real timeout on a user transfer
        mute_byte  = 8'h5B;
        i_req_data = 8'h5B;
        i_req      = 1'b1;
        step();
        i_req = 1'b0;
        a_cyc = cyc;
        g = 0;
        while (!o_err && g < 200) begin
            step();
            g++;
        end
        chk("user_tmo_cyc",   cyc - a_cyc, TMO);
        chk("user_tmo_err",   32'(o_err),  1);
        chk("user_tmo_ready", 32'(o_ready), 1);
        mute_en = 1'b0;

        // ---------------- Run B: clear command never answered ----------------
        drv_lat   = 5;
        mute_en   = 1'b1;
        mute_byte = 8'h01;
        do_reset(1);
        check_reset_outputs("rst_b");
        wait_init(400);
        mute_en = 1'b0;
        chk("tinit_done", 32'(o_init_done), 1);
        chk("tinit_err",  32'(o_err),       1);
        chk("tinit_n_en", en_log.size(),    5);
        for (int k = 0; k < 5; k++) begin
            if (k < en_log.size())
                chk($sformatf("tinit_byte%0d", k), 32'(en_log[k]), 32'({4'h0, rom[k]}));
        end
        if (en_log.size() == 5) begin
            chk("tinit_err_cyc",  err_cyc,   en_cyc[2] + TMO);
            chk("tinit_next_en",  en_cyc[3], en_cyc[2] + TMO + 1);
        end
        chk("tinit_done_cyc", cyc - rel, PWR + 1 + 2 * 6 + TMO + 1 + 6 + 5);

        // Reset in the middle of a user transfer
        drv_lat    = 20;
        i_req_rs   = 1'b1;
        i_req_data = 8'h33;
        i_req      = 1'b1;
        step();
        i_req = 1'b0;
        chk("mid_ack", 32'(o_req_ack), 1);
        repeat (3) step();
        chk("mid_busy", 32'(o_ready), 0);
        drv_lat = 5;
        do_reset(1);
        check_reset_outputs("rst_mid");
        check_normal_init("init_c", 5);
        burst("rand", 8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Absolute time limit so the bench always terminates.
    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
